// File: rtl/psum_gb_arb_pkg.sv
// Shared types and defaults for the psum global-buffer arbiter.
// Optional feature macro: PSUM_ARB_STALL_CNT_EN (GB stall counter).
package psum_gb_arb_pkg;

    localparam int PSUM_WIDTH_DEF = 256;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 8;
    localparam int NUM_PSUM_CH    = 3;
    localparam int CH_W           = 2;

    typedef enum logic [CH_W-1:0] {
        CH0 = 2'd0,
        CH1 = 2'd1,
        CH2 = 2'd2
    } ch_e;

    function automatic ch_e next_ch(input ch_e ch);
        unique case (ch)
            CH0:     next_ch = CH1;
            CH1:     next_ch = CH2;
            default: next_ch = CH0;
        endcase
    endfunction

endpackage

// File: rtl/psum_gb_arb_if.sv
// PE psum channels in, global-buffer psum write port out.
// master = arbiter side, slave = PEB/GB environment side.
interface psum_gb_arb_if #(
    parameter int PSUM_WIDTH = 256,
    parameter int ADDR_WIDTH = 8
);
    logic                  psum_val0;
    logic                  psum_val1;
    logic                  psum_val2;
    logic                  psum_rdy0;
    logic                  psum_rdy1;
    logic                  psum_rdy2;
    logic [PSUM_WIDTH-1:0] psum_data0;
    logic [PSUM_WIDTH-1:0] psum_data1;
    logic [PSUM_WIDTH-1:0] psum_data2;
    logic                  gb_val;
    logic                  gb_rdy;
    logic [PSUM_WIDTH-1:0] gb_data;
    logic [1:0]            gb_ch;
    logic [ADDR_WIDTH-1:0] gb_addr;

    modport master (
        input  psum_val0, psum_val1, psum_val2,
        input  psum_data0, psum_data1, psum_data2,
        output psum_rdy0, psum_rdy1, psum_rdy2,
        output gb_val, gb_data, gb_ch, gb_addr,
        input  gb_rdy
    );

    modport slave (
        output psum_val0, psum_val1, psum_val2,
        output psum_data0, psum_data1, psum_data2,
        input  psum_rdy0, psum_rdy1, psum_rdy2,
        input  gb_val, gb_data, gb_ch, gb_addr,
        output gb_rdy
    );
endinterface

// File: rtl/psum_gb_arb_rr_arb3.sv
// 3-way round-robin arbiter; pointer advances past the granted
// channel only when the grant is actually consumed.
module rr_arb3
    import psum_gb_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       adv,
    input  logic [2:0] req,
    output logic [2:0] gnt
);

    ch_e ptr_q;
    ch_e ptr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= CH0;
        else        ptr_q <= ptr_d;
    end

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        unique case (ptr_q)
            CH0: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
            CH1: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            default: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
        endcase
        if (clr) begin
            ptr_d = CH0;
        end else if (adv) begin
            unique case (1'b1)
                gnt[0]:  ptr_d = next_ch(CH0);
                gnt[1]:  ptr_d = next_ch(CH1);
                gnt[2]:  ptr_d = next_ch(CH2);
                default: ptr_d = ptr_q;
            endcase
        end
    end

endmodule

// File: rtl/psum_gb_arb.sv
// Merges three PE psum channels onto the GB psum write port.
// Optional macro PSUM_ARB_STALL_CNT_EN enables the stall counter.
module psum_gb_arb
    import psum_gb_arb_pkg::*;
#(
    parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 next_block,
    input  logic [CNT_WIDTH-1:0] cfg_num,
    psum_gb_arb_if.master        bus,
    output logic                 blk_fnh,
    output logic [15:0]          stall_cnt
);

    logic [NUM_PSUM_CH-1:0] val;
    logic [NUM_PSUM_CH-1:0] elig;
    logic [NUM_PSUM_CH-1:0] gnt;
    logic [NUM_PSUM_CH-1:0] rdy;
    logic                   load_en;
    logic                   acc;
    logic                   quota_met;

    logic [CNT_WIDTH-1:0]  quota_q;
    logic [CNT_WIDTH-1:0]  cnt_q  [NUM_PSUM_CH];
    logic [ADDR_WIDTH-1:0] addr_q [NUM_PSUM_CH];

    logic [CH_W-1:0]       sel_ch;
    logic [PSUM_WIDTH-1:0] sel_data;
    logic [ADDR_WIDTH-1:0] sel_addr;

    logic                  gb_val_q;
    logic [PSUM_WIDTH-1:0] gb_data_q;
    logic [CH_W-1:0]       gb_ch_q;
    logic [ADDR_WIDTH-1:0] gb_addr_q;

    assign val = {bus.psum_val2, bus.psum_val1, bus.psum_val0};
    assign load_en = !gb_val_q | bus.gb_rdy;

    always_comb begin
        elig      = '0;
        quota_met = 1'b1;
        for (int i = 0; i < NUM_PSUM_CH; i++) begin
            elig[i] = val[i] & (cnt_q[i] != quota_q);
            if (cnt_q[i] != quota_q) quota_met = 1'b0;
        end
    end

    rr_arb3 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (next_block),
        .adv   (acc),
        .req   (elig),
        .gnt   (gnt)
    );

    // Ready is gated on rst_n so nothing is taken before the first reset edge.
    assign rdy = gnt & {NUM_PSUM_CH{load_en & !next_block & rst_n}};
    assign acc = |rdy;

    assign bus.psum_rdy0 = rdy[0];
    assign bus.psum_rdy1 = rdy[1];
    assign bus.psum_rdy2 = rdy[2];

    always_comb begin
        sel_ch   = '0;
        sel_data = '0;
        sel_addr = '0;
        unique case (1'b1)
            gnt[0]: begin
                sel_ch   = CH0;
                sel_data = bus.psum_data0;
                sel_addr = addr_q[0];
            end
            gnt[1]: begin
                sel_ch   = CH1;
                sel_data = bus.psum_data1;
                sel_addr = addr_q[1];
            end
            gnt[2]: begin
                sel_ch   = CH2;
                sel_data = bus.psum_data2;
                sel_addr = addr_q[2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gb_val_q  <= 1'b0;
            gb_data_q <= '0;
            gb_ch_q   <= '0;
            gb_addr_q <= '0;
        end else if (load_en) begin
            gb_val_q <= acc;
            if (acc) begin
                gb_data_q <= sel_data;
                gb_ch_q   <= sel_ch;
                gb_addr_q <= sel_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quota_q <= '0;
            for (int i = 0; i < NUM_PSUM_CH; i++) begin
                cnt_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else if (next_block) begin
            quota_q <= cfg_num;
            for (int i = 0; i < NUM_PSUM_CH; i++) begin
                cnt_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PSUM_CH; i++) begin
                if (rdy[i]) begin
                    cnt_q[i]  <= cnt_q[i] + CNT_WIDTH'(1);
                    addr_q[i] <= addr_q[i] + ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign bus.gb_val  = gb_val_q;
    assign bus.gb_data = gb_data_q;
    assign bus.gb_ch   = gb_ch_q;
    assign bus.gb_addr = gb_addr_q;
    assign blk_fnh     = quota_met & !gb_val_q;

`ifdef PSUM_ARB_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_q <= '0;
        else if (next_block)
            stall_q <= '0;
        else if (gb_val_q & !bus.gb_rdy & (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_psum_gb_arb.sv
// Directed self-checking bench for psum_gb_arb.
// Built with ADDR_WIDTH=2 so address wrap is reachable.
module tb_psum_gb_arb;

    localparam int PW = 16;
    localparam int AW = 2;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          next_block;
    logic [CW-1:0] cfg_num;
    logic          blk_fnh;
    logic [15:0]   stall_cnt;

    int n_chk;
    int n_fail;

    psum_gb_arb_if #(.PSUM_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

    psum_gb_arb #(
        .PSUM_WIDTH (PW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .next_block (next_block),
        .cfg_num    (cfg_num),
        .bus        (bus.master),
        .blk_fnh    (blk_fnh),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_nb(input logic [CW-1:0] cfg);
        next_block = 1'b1;
        cfg_num    = cfg;
        step();
        next_block = 1'b0;
    endtask

    task automatic set_val(input logic [2:0] v);
        bus.psum_val0 = v[0];
        bus.psum_val1 = v[1];
        bus.psum_val2 = v[2];
    endtask

    task automatic test_reset();
        logic [2:0] r;
        rst_n      = 1'b0;
        next_block = 1'b0;
        cfg_num    = '0;
        bus.gb_rdy = 1'b0;
        set_val(3'b000);
        bus.psum_data0 = 16'h0;
        bus.psum_data1 = 16'h0;
        bus.psum_data2 = 16'h0;
        step();
        step();
        r = {bus.psum_rdy2, bus.psum_rdy1, bus.psum_rdy0};
        n_chk++;
        if ({bus.gb_val, bus.gb_ch, bus.gb_addr, bus.gb_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_out got %b/%0d/%0d/%h want 0/0/0/0",
                     bus.gb_val, bus.gb_ch, bus.gb_addr, bus.gb_data);
        end
        n_chk++;
        if (r !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_rdy got %b want 000", r);
        end
        n_chk++;
        if (blk_fnh !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_fnh got %b want 1", blk_fnh);
        end
        n_chk++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall got %0d want 0", stall_cnt);
        end
        rst_n = 1'b1;
        step();
        // quota 0 after reset: nothing may be granted
        set_val(3'b111);
        bus.gb_rdy = 1'b1;
        #1;
        r = {bus.psum_rdy2, bus.psum_rdy1, bus.psum_rdy0};
        n_chk++;
        if (r !== 3'b000) begin
            n_fail++;
            $display("FAIL zero_quota_rdy got %b want 000", r);
        end
        step();
        n_chk++;
        if ({bus.gb_val, blk_fnh} !== 2'b01) begin
            n_fail++;
            $display("FAIL zero_quota_out got val=%b fnh=%b want 0/1",
                     bus.gb_val, blk_fnh);
        end
        set_val(3'b000);
    endtask

    task automatic test_fairness();
        logic [1:0]    ech;
        logic [AW-1:0] ead;
        logic [PW-1:0] edt;
        pulse_nb(8'd4);
        bus.psum_data0 = 16'hA0A0;
        bus.psum_data1 = 16'hA1A1;
        bus.psum_data2 = 16'hA2A2;
        bus.gb_rdy = 1'b1;
        set_val(3'b111);
        for (int k = 0; k < 12; k++) begin
            step();
            ech = 2'(k % 3);
            ead = AW'(k / 3);
            edt = (ech == 2'd0) ? 16'hA0A0 :
                  (ech == 2'd1) ? 16'hA1A1 : 16'hA2A2;
            n_chk++;
            if ({bus.gb_val, bus.gb_ch, bus.gb_addr, bus.gb_data}
                !== {1'b1, ech, ead, edt}) begin
                n_fail++;
                $display("FAIL fair_word%0d got %b/%0d/%0d/%h want 1/%0d/%0d/%h",
                         k, bus.gb_val, bus.gb_ch, bus.gb_addr, bus.gb_data,
                         ech, ead, edt);
            end
            n_chk++;
            if (blk_fnh !== 1'b0) begin
                n_fail++;
                $display("FAIL fair_fnh%0d got %b want 0", k, blk_fnh);
            end
        end
        set_val(3'b000);
        step();
        n_chk++;
        if ({bus.gb_val, blk_fnh} !== 2'b01) begin
            n_fail++;
            $display("FAIL fair_done got val=%b fnh=%b want 0/1",
                     bus.gb_val, blk_fnh);
        end
    endtask

    task automatic test_backpressure();
        pulse_nb(8'd4);
        bus.gb_rdy = 1'b0;
        bus.psum_data1 = 16'hB1B1;
        set_val(3'b010);
        #1;
        n_chk++;
        if (bus.psum_rdy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first_rdy got %b want 1", bus.psum_rdy1);
        end
        step();
        bus.psum_data1 = 16'hB2B2;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++;
            if ({bus.gb_val, bus.gb_ch, bus.gb_addr, bus.gb_data,
                 bus.psum_rdy1} !== {1'b1, 2'd1, 2'd0, 16'hB1B1, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold%0d got %b/%0d/%0d/%h rdy=%b want 1/1/0/b1b1 rdy=0",
                         i, bus.gb_val, bus.gb_ch, bus.gb_addr, bus.gb_data,
                         bus.psum_rdy1);
            end
            step();
        end
        n_chk++;
        if ({bus.gb_val, bus.gb_data} !== {1'b1, 16'hB1B1}) begin
            n_fail++;
            $display("FAIL bp_end got %b/%h want 1/b1b1", bus.gb_val, bus.gb_data);
        end
`ifdef PSUM_ARB_STALL_CNT_EN
        n_chk++;
        if (stall_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL bp_stall got %0d want 5", stall_cnt);
        end
`endif
        bus.gb_rdy = 1'b1;
        #1;
        n_chk++;
        if (bus.psum_rdy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_rdy got %b want 1", bus.psum_rdy1);
        end
        step();
        n_chk++;
        if ({bus.gb_val, bus.gb_ch, bus.gb_addr, bus.gb_data}
            !== {1'b1, 2'd1, 2'd1, 16'hB2B2}) begin
            n_fail++;
            $display("FAIL bp_second got %b/%0d/%0d/%h want 1/1/1/b2b2",
                     bus.gb_val, bus.gb_ch, bus.gb_addr, bus.gb_data);
        end
        set_val(3'b000);
        step();
        n_chk++;
        if (bus.gb_val !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain got %b want 0", bus.gb_val);
        end
    endtask

    task automatic test_quota();
        logic [1:0]    ech;
        logic [AW-1:0] ead;
        pulse_nb(8'd2);
        bus.gb_rdy = 1'b1;
        bus.psum_data0 = 16'hC0C0;
        bus.psum_data1 = 16'hC1C1;
        bus.psum_data2 = 16'hC2C2;
        set_val(3'b001);
        for (int k = 0; k < 2; k++) begin
            step();
            n_chk++;
            if ({bus.gb_val, bus.gb_ch, bus.gb_addr}
                !== {1'b1, 2'd0, AW'(k)}) begin
                n_fail++;
                $display("FAIL quota_ch0_%0d got %b/%0d/%0d want 1/0/%0d",
                         k, bus.gb_val, bus.gb_ch, bus.gb_addr, k);
            end
        end
        for (int k = 0; k < 2; k++) begin
            step();
            n_chk++;
            if ({bus.gb_val, bus.psum_rdy0, blk_fnh} !== 3'b000) begin
                n_fail++;
                $display("FAIL quota_gate%0d got val=%b rdy0=%b fnh=%b want 0/0/0",
                         k, bus.gb_val, bus.psum_rdy0, blk_fnh);
            end
        end
        set_val(3'b111);
        for (int k = 0; k < 4; k++) begin
            step();
            ech = (k % 2 == 0) ? 2'd1 : 2'd2;
            ead = AW'(k / 2);
            n_chk++;
            if ({bus.gb_val, bus.gb_ch, bus.gb_addr, bus.psum_rdy0, blk_fnh}
                !== {1'b1, ech, ead, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL quota_rest%0d got %b/%0d/%0d rdy0=%b fnh=%b want 1/%0d/%0d 0/0",
                         k, bus.gb_val, bus.gb_ch, bus.gb_addr,
                         bus.psum_rdy0, blk_fnh, ech, ead);
            end
        end
        step();
        n_chk++;
        if ({bus.gb_val, blk_fnh} !== 2'b01) begin
            n_fail++;
            $display("FAIL quota_done got val=%b fnh=%b want 0/1",
                     bus.gb_val, blk_fnh);
        end
        set_val(3'b000);
    endtask

    task automatic test_addr_wrap();
        logic [1:0]    ech;
        logic [AW-1:0] ead;
        pulse_nb(8'd6);
        bus.gb_rdy = 1'b1;
        set_val(3'b011);
        for (int k = 0; k < 12; k++) begin
            step();
            ech = 2'(k % 2);
            ead = AW'((k / 2) % 4);
            n_chk++;
            if ({bus.gb_val, bus.gb_ch, bus.gb_addr} !== {1'b1, ech, ead}) begin
                n_fail++;
                $display("FAIL wrap_ch01_%0d got %b/%0d/%0d want 1/%0d/%0d",
                         k, bus.gb_val, bus.gb_ch, bus.gb_addr, ech, ead);
            end
        end
        set_val(3'b100);
        for (int k = 0; k < 6; k++) begin
            step();
            ead = AW'(k % 4);
            n_chk++;
            if ({bus.gb_val, bus.gb_ch, bus.gb_addr} !== {1'b1, 2'd2, ead}) begin
                n_fail++;
                $display("FAIL wrap_ch2_%0d got %b/%0d/%0d want 1/2/%0d",
                         k, bus.gb_val, bus.gb_ch, bus.gb_addr, ead);
            end
        end
        set_val(3'b000);
        step();
        n_chk++;
        if ({bus.gb_val, blk_fnh} !== 2'b01) begin
            n_fail++;
            $display("FAIL wrap_done got val=%b fnh=%b want 0/1",
                     bus.gb_val, blk_fnh);
        end
    endtask

    task automatic test_nb_pending();
        pulse_nb(8'd3);
        bus.gb_rdy = 1'b0;
        bus.psum_data0 = 16'hD0D0;
        set_val(3'b001);
        step();
        n_chk++;
        if ({bus.gb_val, bus.gb_ch, bus.gb_addr, bus.gb_data}
            !== {1'b1, 2'd0, 2'd0, 16'hD0D0}) begin
            n_fail++;
            $display("FAIL nbp_load got %b/%0d/%0d/%h want 1/0/0/d0d0",
                     bus.gb_val, bus.gb_ch, bus.gb_addr, bus.gb_data);
        end
        bus.psum_data0 = 16'hD1D1;
        next_block = 1'b1;
        cfg_num    = 8'd3;
        bus.gb_rdy = 1'b1;
        #1;
        n_chk++;
        if ({bus.psum_rdy2, bus.psum_rdy1, bus.psum_rdy0} !== 3'b000) begin
            n_fail++;
            $display("FAIL nbp_rdy got %b want 000",
                     {bus.psum_rdy2, bus.psum_rdy1, bus.psum_rdy0});
        end
        n_chk++;
        if ({bus.gb_val, bus.gb_ch, bus.gb_addr, bus.gb_data}
            !== {1'b1, 2'd0, 2'd0, 16'hD0D0}) begin
            n_fail++;
            $display("FAIL nbp_drain got %b/%0d/%0d/%h want 1/0/0/d0d0",
                     bus.gb_val, bus.gb_ch, bus.gb_addr, bus.gb_data);
        end
        step();
        next_block = 1'b0;
        #1;
        n_chk++;
        if ({bus.gb_val, blk_fnh, bus.psum_rdy0} !== 3'b001) begin
            n_fail++;
            $display("FAIL nbp_after got val=%b fnh=%b rdy0=%b want 0/0/1",
                     bus.gb_val, blk_fnh, bus.psum_rdy0);
        end
`ifdef PSUM_ARB_STALL_CNT_EN
        n_chk++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL nbp_stall got %0d want 0", stall_cnt);
        end
`endif
        step();
        n_chk++;
        if ({bus.gb_val, bus.gb_ch, bus.gb_addr, bus.gb_data}
            !== {1'b1, 2'd0, 2'd0, 16'hD1D1}) begin
            n_fail++;
            $display("FAIL nbp_new got %b/%0d/%0d/%h want 1/0/0/d1d1",
                     bus.gb_val, bus.gb_ch, bus.gb_addr, bus.gb_data);
        end
        set_val(3'b000);
        step();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_fairness();
        test_backpressure();
        test_quota();
        test_addr_wrap();
        test_nb_pending();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
